// File: rtl/flit_packetizer.sv
// Wraps an AXI-Stream payload into mesh NoC packets: one header flit carrying
// target/source coordinates, then pass-through body flits, split every MAX_BODY_FLITS.
module flit_packetizer #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int ROUTER_X       = 0,
  parameter int ROUTER_Y       = 0,
  parameter int MAX_BODY_FLITS = 8,
  localparam int X_W           = $clog2(MAX_ROUTERS_X),
  localparam int Y_W           = $clog2(MAX_ROUTERS_Y)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tlast_i,
  input  logic [X_W-1:0]        dest_x_i,
  input  logic [Y_W-1:0]        dest_y_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic [15:0]           pkt_count_o
);

  localparam int CNT_W    = $clog2(MAX_BODY_FLITS + 1);
  localparam int SRC_X_LO = X_W + Y_W;
  localparam int SRC_Y_LO = 2 * X_W + Y_W;
  localparam int CONT_BIT = 2 * (X_W + Y_W);
  localparam logic [CNT_W-1:0] BODY_LIMIT = CNT_W'(MAX_BODY_FLITS - 1);

  generate
    if (DATA_WIDTH < 2 * (X_W + Y_W) + 1) begin : g_width_check
      $error("flit_packetizer: DATA_WIDTH too small for header fields");
    end
    if (MAX_BODY_FLITS < 1) begin : g_body_check
      $error("flit_packetizer: MAX_BODY_FLITS must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } state_t;

  state_t             state_reg;
  logic [X_W-1:0]     dest_x_reg;
  logic [Y_W-1:0]     dest_y_reg;
  logic               cont_reg;
  logic [CNT_W-1:0]   body_cnt_reg;
  logic [15:0]        pkt_count_reg;

  logic [DATA_WIDTH-1:0] header_word;
  logic                  at_limit;
  logic                  body_xfer;

  // Header is built only from registered fields, so it stays stable while stalled.
  always_comb begin
    header_word                          = '0;
    header_word[X_W-1:0]                 = dest_x_reg;
    header_word[SRC_X_LO-1:X_W]          = dest_y_reg;
    header_word[SRC_Y_LO-1:SRC_X_LO]     = X_W'(ROUTER_X);
    header_word[CONT_BIT-1:SRC_Y_LO]     = Y_W'(ROUTER_Y);
    header_word[CONT_BIT]                = cont_reg;
  end

  assign at_limit  = (body_cnt_reg == BODY_LIMIT);
  assign body_xfer = (state_reg == ST_BODY) && s_tvalid_i && m_tready_i;

  always_comb begin
    m_tdata_o  = '0;
    m_tvalid_o = 1'b0;
    m_tlast_o  = 1'b0;
    s_tready_o = 1'b0;
    case (state_reg)
      ST_HEADER: begin
        m_tdata_o  = header_word;
        m_tvalid_o = 1'b1;
      end
      ST_BODY: begin
        m_tdata_o  = s_tdata_i;
        m_tvalid_o = s_tvalid_i;
        m_tlast_o  = s_tlast_i || at_limit;
        s_tready_o = m_tready_i;
      end
      default: ;
    endcase
  end

  assign pkt_count_o = pkt_count_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      dest_x_reg    <= '0;
      dest_y_reg    <= '0;
      cont_reg      <= 1'b0;
      body_cnt_reg  <= '0;
      pkt_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (s_tvalid_i) begin
            dest_x_reg   <= dest_x_i;
            dest_y_reg   <= dest_y_i;
            cont_reg     <= 1'b0;
            body_cnt_reg <= '0;
            state_reg    <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (m_tready_i) begin
            pkt_count_reg <= pkt_count_reg + 16'd1;
            state_reg     <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (body_xfer) begin
            if (s_tlast_i) begin
              body_cnt_reg <= body_cnt_reg + 1'b1;
              state_reg    <= ST_IDLE;
            end else if (at_limit) begin
              // Forced split: re-announce the same destination with cont set.
              cont_reg     <= 1'b1;
              body_cnt_reg <= '0;
              state_reg    <= ST_HEADER;
            end else begin
              body_cnt_reg <= body_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_packetizer.sv
// Randomized bench: expected flit stream is derived per packet from the
// segmentation rules and compared beat by beat against the DUT output.
module tb_flit_packetizer;

  localparam int DW = 32;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int MB = 8;
  localparam int RX = 0;
  localparam int RY = 0;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] s_tdata_i;
  logic          s_tvalid_i;
  logic          s_tready_o;
  logic          s_tlast_i;
  logic [XW-1:0] dest_x_i;
  logic [YW-1:0] dest_y_i;
  logic [DW-1:0] m_tdata_o;
  logic          m_tvalid_o;
  logic          m_tready_i;
  logic          m_tlast_o;
  logic [15:0]   pkt_count_o;

  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          hdr;
  } flit_t;

  flit_packetizer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_tdata_i   (s_tdata_i),
    .s_tvalid_i  (s_tvalid_i),
    .s_tready_o  (s_tready_o),
    .s_tlast_i   (s_tlast_i),
    .dest_x_i    (dest_x_i),
    .dest_y_i    (dest_y_i),
    .m_tdata_o   (m_tdata_o),
    .m_tvalid_o  (m_tvalid_o),
    .m_tready_i  (m_tready_i),
    .m_tlast_o   (m_tlast_o),
    .pkt_count_o (pkt_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr_word(input int x, input int y, input int cont);
    int v;
    v = x + (y << XW) + (RX << (XW + YW)) + (RY << (2 * XW + YW)) + (cont << (2 * (XW + YW)));
    return DW'(v);
  endfunction

  function automatic logic pick(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // Sends one payload of len beats and checks every output flit against the model.
  task automatic run_packet(input int len, input int dx, input int dy,
                            input int vpct, input int rpct, input int hold);
    logic [DW-1:0] beats[$];
    flit_t         exp_q[$];
    flit_t         f;
    int            beat, cyc, first_valid;
    logic          in_hs, out_hs, hdr_wait;
    logic [DW-1:0] prev_data;

    for (int i = 0; i < len; i++) beats.push_back(DW'($urandom));
    for (int i = 0; i < len; i++) begin
      if (i % MB == 0) exp_q.push_back('{hdr_word(dx, dy, (i != 0) ? 1 : 0), 1'b0, 1'b1});
      exp_q.push_back('{beats[i], (i == len - 1) || (i % MB == MB - 1), 1'b0});
    end
    exp_pkts += (len + MB - 1) / MB;

    beat = 0; cyc = 0; first_valid = -1; hdr_wait = 0; prev_data = '0;
    dest_x_i   = XW'(dx);
    dest_y_i   = YW'(dy);
    s_tvalid_i = pick(vpct);
    s_tdata_i  = beats[0];
    s_tlast_i  = (len == 1);
    m_tready_i = (hold > 0) ? 1'b0 : pick(rpct);

    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge clk_i);
      if (m_tvalid_o && first_valid < 0) first_valid = cyc;
      if (hdr_wait) begin
        check_eq("hdr_hold_valid", 64'(m_tvalid_o), 64'd1);
        check_eq("hdr_hold_data", 64'(m_tdata_o), 64'(prev_data));
      end
      if (exp_q[0].hdr) check_eq("hdr_s_tready", 64'(s_tready_o), 64'd0);
      out_hs    = m_tvalid_o && m_tready_i;
      in_hs     = s_tvalid_i && s_tready_o;
      hdr_wait  = exp_q[0].hdr && m_tvalid_o && !m_tready_i;
      prev_data = m_tdata_o;
      if (out_hs) begin
        f = exp_q.pop_front();
        check_eq(f.hdr ? "header_flit" : "body_flit", {31'd0, m_tlast_o, m_tdata_o}, {31'd0, f.last, f.data});
      end
      @(posedge clk_i);
      #1;
      cyc++;
      if (in_hs) beat++;
      if (beat < len) begin
        if (!s_tvalid_i || in_hs) s_tvalid_i = pick(vpct);
        s_tdata_i = beats[beat];
        s_tlast_i = (beat == len - 1);
      end else begin
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
      end
      m_tready_i = (cyc < hold) ? 1'b0 : pick(rpct);
      if (beat == 0) begin
        dest_x_i = XW'(dx);
        dest_y_i = YW'(dy);
      end else begin
        dest_x_i = XW'($urandom);
        dest_y_i = YW'($urandom);
      end
    end
    if (exp_q.size() > 0) check_eq("timeout_pending", 64'(exp_q.size()), 64'd0);
    if (vpct == 100 && hold == 0) check_eq("hdr_latency", 64'(first_valid), 64'd1);
    @(negedge clk_i);
    check_eq("pkt_count", 64'(pkt_count_o), 64'(exp_pkts & 16'hFFFF));
    check_eq("idle_valid", 64'(m_tvalid_o), 64'd0);
    $display("packet len=%0d dest=(%0d,%0d) done in %0d cycles", len, dx, dy, cyc);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i      = 1'b1;
    s_tdata_i  = '0;
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    dest_x_i   = '0;
    dest_y_i   = '0;
    m_tready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    s_tvalid_i = 1'b1;
    m_tready_i = 1'b1;
    @(negedge clk_i);
    check_eq("rst_m_tvalid", 64'(m_tvalid_o), 64'd0);
    check_eq("rst_s_tready", 64'(s_tready_o), 64'd0);
    check_eq("rst_m_tlast", 64'(m_tlast_o), 64'd0);
    check_eq("rst_m_tdata", 64'(m_tdata_o), 64'd0);
    check_eq("rst_pkt_count", 64'(pkt_count_o), 64'd0);
    @(posedge clk_i);
    #1;
    s_tvalid_i = 1'b0;
    rst_i      = 1'b0;
    @(posedge clk_i);
    #1;

    run_packet(3, 3, 2, 100, 100, 0);
    run_packet(20, 1, 1, 100, 100, 0);
    run_packet(8, 2, 1, 100, 100, 0);
    run_packet(5, 2, 3, 100, 100, 5);
    run_packet(17, 0, 3, 100, 100, 0);

    // Abandon a packet after two body flits.
    dest_x_i   = 2'd1;
    dest_y_i   = 2'd2;
    s_tvalid_i = 1'b1;
    s_tlast_i  = 1'b0;
    s_tdata_i  = DW'($urandom);
    m_tready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i      = 1'b1;
    s_tvalid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("midrst_m_tvalid", 64'(m_tvalid_o), 64'd0);
    check_eq("midrst_pkt_count", 64'(pkt_count_o), 64'd0);
    exp_pkts = 0;
    @(posedge clk_i);
    #1;
    run_packet(4, 3, 1, 100, 100, 0);

    for (int p = 0; p < 40; p++) begin
      run_packet($urandom_range(25, 1), $urandom_range(3), $urandom_range(3),
                 $urandom_range(100, 40), $urandom_range(100, 40), $urandom_range(3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
